// File: rtl/multi_channel_clock_gen_pkg.sv
// Shared types and constants for the power-sequenced multi-channel clock generator.
package multi_channel_clock_gen_pkg;

  typedef enum logic [1:0] {
    PG_OFF     = 2'd0,
    PG_FILTER  = 2'd1,
    PG_STARTUP = 2'd2,
    PG_RUN     = 2'd3
  } pg_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/multi_channel_clock_gen_clock_div_channel.sv
// One 50%-duty divided clock with active/pending ratio, glitch-free ratio
// switching at period boundaries and runt-free enable handling.
module clock_div_channel
  import multi_channel_clock_gen_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] ratio,
  input  logic                 load,
  input  logic                 enable,
  output logic                 clock_out,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] act_q, act_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 flag_q, flag_d;
  logic                 on_q, on_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;

  // Divider next-state; a period starts with the low phase, so it ends on the fall.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    flag_d = flag_q;
    on_d   = on_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (!run) begin
      cnt_d = '0;
      clk_d = 1'b0;
      on_d  = 1'b0;
    end else if (!on_q) begin
      if (enable) begin
        on_d  = 1'b1;
        cnt_d = '0;
        clk_d = 1'b0;
      end
    end else if (!enable && !clk_q) begin
      on_d  = 1'b0;
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (cnt_q == act_q) begin
      cnt_d = '0;
      clk_d = ~clk_q;
      if (clk_q) begin
        if (flag_q) begin
          act_d  = pend_q;
          flag_d = 1'b0;
        end
        if (!enable) on_d = 1'b0;
      end else begin
        tick_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end

    // An idle channel has no period to protect, so ratios take effect at once.
    if (!on_q && flag_q) begin
      act_d  = pend_q;
      flag_d = 1'b0;
    end
    if (load) begin
      pend_d = ratio;
      if (on_q) begin
        flag_d = 1'b1;
      end else begin
        act_d  = ratio;
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      act_q  <= '0;
      pend_q <= '0;
      flag_q <= 1'b0;
      on_q   <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      flag_q <= flag_d;
      on_q   <= on_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clock_out = clk_q;
  assign tick      = tick_q;

endmodule

// File: rtl/multi_channel_clock_gen.sv
// Power-good synchroniser, debounce/startup sequencer and a bank of divided
// clock channels that only run while the rail is stable.
module multi_channel_clock_gen
  import multi_channel_clock_gen_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned STARTUP_CYCLES = 1000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          power,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_ratio,
  input  logic [CHANNELS-1:0]           div_load,
  input  logic [CHANNELS-1:0]           chan_enable,
  output logic [CHANNELS-1:0]           clock_out,
  output logic [CHANNELS-1:0]           tick,
  output logic                          stable,
  output logic [1:0]                    pg_state
);

  localparam int unsigned CNT_MAX = (FILTER_CYCLES > STARTUP_CYCLES) ? FILTER_CYCLES : STARTUP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync2;
  pg_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q;
  logic                   chan_run_c;

  assign sync2 = sync_q[SYNC_STAGES-1];

  // Sequencer next-state: any loss of the synchronised rail drops to OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PG_OFF: begin
        cnt_d = '0;
        if (sync2) state_d = PG_FILTER;
      end
      PG_FILTER: begin
        if (!sync2) begin
          state_d = PG_OFF;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
          state_d = PG_STARTUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PG_STARTUP: begin
        if (!sync2) begin
          state_d = PG_OFF;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
          state_d = PG_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PG_RUN: begin
        cnt_d = '0;
        if (!sync2) state_d = PG_OFF;
      end
      default: begin
        state_d = PG_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q   <= '0;
      state_q  <= PG_OFF;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], power};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= (state_d == PG_RUN);
    end
  end

  // Channels stop on the very edge that leaves RUN, not one cycle later.
  assign chan_run_c = (state_q == PG_RUN) && sync2;

  assign stable   = stable_q;
  assign pg_state = state_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clock_div_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .run       (chan_run_c),
      .ratio     (div_ratio[i*DIV_WIDTH +: DIV_WIDTH]),
      .load      (div_load[i]),
      .enable    (chan_enable[i]),
      .clock_out (clock_out[i]),
      .tick      (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_gen.sv
// Directed bench: power sequencing, dividers, ratio switching, enable and reset corners.
module tb_multi_channel_clock_gen;

  localparam int unsigned CH  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned NV  = 36;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           power;
  logic [CH*DW-1:0] div_ratio;
  logic [CH-1:0]  div_load;
  logic [CH-1:0]  chan_enable;
  logic [CH-1:0]  clock_out;
  logic [CH-1:0]  tick;
  logic           stable;
  logic [1:0]     pg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [CH-1:0]    load;
    logic [CH*DW-1:0] ratio;
    logic [CH-1:0]    en;
    logic [CH-1:0]    exp_clk;
    logic [CH-1:0]    exp_tick;
  } vec_t;

  vec_t vecs [NV];

  multi_channel_clock_gen #(
    .CHANNELS       (CH),
    .DIV_WIDTH      (DW),
    .FILTER_CYCLES  (2),
    .STARTUP_CYCLES (10)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .power       (power),
    .div_ratio   (div_ratio),
    .div_load    (div_load),
    .chan_enable (chan_enable),
    .clock_out   (clock_out),
    .tick        (tick),
    .stable      (stable),
    .pg_state    (pg_state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Power assumed low with sequencer in OFF; RUN is expected after edge 15.
  task automatic powerup(input string tag);
    logic [1:0] exp_pg;
    power = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_pg = (k <= 2) ? 2'd0 : (k <= 4) ? 2'd1 : (k <= 14) ? 2'd2 : 2'd3;
      chk($sformatf("%s_pg_e%0d", tag, k), 32'(pg_state), 32'(exp_pg));
      chk($sformatf("%s_stable_e%0d", tag, k), 32'(stable), 32'(k >= 15));
      chk($sformatf("%s_clk_e%0d", tag, k), 32'(clock_out), 32'(0));
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0011, 32'h0000_0002, 4'b0011, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0000, 32'h0, 4'b0011, 4'b0010, 4'b0010};
    vecs[2]  = '{4'b0000, 32'h0, 4'b0011, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0000, 32'h0, 4'b0011, 4'b0011, 4'b0011};
    vecs[4]  = '{4'b0000, 32'h0, 4'b0011, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b0000, 32'h0, 4'b0011, 4'b0011, 4'b0010};
    vecs[6]  = '{4'b0000, 32'h0, 4'b0011, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0000, 32'h0, 4'b0011, 4'b0010, 4'b0010};
    vecs[8]  = '{4'b0000, 32'h0, 4'b0011, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b0000, 32'h0, 4'b0011, 4'b0011, 4'b0011};
    vecs[10] = '{4'b0001, 32'h0, 4'b0011, 4'b0001, 4'b0000};
    vecs[11] = '{4'b0000, 32'h0, 4'b0011, 4'b0011, 4'b0010};
    vecs[12] = '{4'b0000, 32'h0, 4'b0011, 4'b0000, 4'b0000};
    vecs[13] = '{4'b0000, 32'h0, 4'b0011, 4'b0011, 4'b0011};
    vecs[14] = '{4'b0000, 32'h0, 4'b0011, 4'b0000, 4'b0000};
    vecs[15] = '{4'b0000, 32'h0, 4'b0011, 4'b0011, 4'b0011};
    vecs[16] = '{4'b0100, 32'h0002_0000, 4'b0111, 4'b0000, 4'b0000};
    vecs[17] = '{4'b0000, 32'h0, 4'b0111, 4'b0011, 4'b0011};
    vecs[18] = '{4'b0000, 32'h0, 4'b0111, 4'b0000, 4'b0000};
    vecs[19] = '{4'b0000, 32'h0, 4'b0111, 4'b0111, 4'b0111};
    vecs[20] = '{4'b0000, 32'h0, 4'b0011, 4'b0100, 4'b0000};
    vecs[21] = '{4'b0000, 32'h0, 4'b0011, 4'b0111, 4'b0011};
    vecs[22] = '{4'b0000, 32'h0, 4'b0011, 4'b0000, 4'b0000};
    vecs[23] = '{4'b0000, 32'h0, 4'b0011, 4'b0011, 4'b0011};
    vecs[24] = '{4'b0000, 32'h0, 4'b0011, 4'b0000, 4'b0000};
    vecs[25] = '{4'b0000, 32'h0, 4'b0111, 4'b0011, 4'b0011};
    vecs[26] = '{4'b0000, 32'h0, 4'b0111, 4'b0000, 4'b0000};
    vecs[27] = '{4'b0000, 32'h0, 4'b0111, 4'b0011, 4'b0011};
    vecs[28] = '{4'b0000, 32'h0, 4'b0111, 4'b0100, 4'b0100};
    vecs[29] = '{4'b0000, 32'h0, 4'b0111, 4'b0111, 4'b0011};
    vecs[30] = '{4'b0000, 32'h0, 4'b0111, 4'b0100, 4'b0000};
    vecs[31] = '{4'b0000, 32'h0, 4'b0111, 4'b0011, 4'b0011};
    vecs[32] = '{4'b0000, 32'h0, 4'b0111, 4'b0000, 4'b0000};
    vecs[33] = '{4'b0000, 32'h0, 4'b0101, 4'b0001, 4'b0001};
    vecs[34] = '{4'b0000, 32'h0, 4'b0101, 4'b0100, 4'b0100};
    vecs[35] = '{4'b0000, 32'h0, 4'b0101, 4'b0101, 4'b0001};

    reset_n     = 1'b0;
    power       = 1'b0;
    div_ratio   = '0;
    div_load    = '0;
    chan_enable = '0;

    step();
    step();
    chk("rst_pg", 32'(pg_state), 32'(0));
    chk("rst_stable", 32'(stable), 32'(0));
    chk("rst_clk", 32'(clock_out), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    reset_n = 1'b1;

    // Short rail glitch: FILTER is entered but STARTUP must never be reached.
    power = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) power = 1'b0;
      chk($sformatf("glitch_pg_e%0d", k), 32'(pg_state), 32'((k == 3 || k == 4) ? 1 : 0));
      chk($sformatf("glitch_stable_e%0d", k), 32'(stable), 32'(0));
    end

    powerup("pu1");

    // Divider table: inputs are sampled on edge i+1, expectations observed after it.
    for (int i = 0; i < int'(NV); i++) begin
      div_load    = vecs[i].load;
      div_ratio   = vecs[i].ratio;
      chan_enable = vecs[i].en;
      step();
      chk($sformatf("div_clk_r%0d", i + 1), 32'(clock_out), 32'(vecs[i].exp_clk));
      chk($sformatf("div_tick_r%0d", i + 1), 32'(tick), 32'(vecs[i].exp_tick));
    end
    div_load  = '0;
    div_ratio = '0;

    // Power loss in RUN: two synchroniser edges, then OFF with channels cleared.
    power = 1'b0;
    step();
    chk("loss_pg_e1", 32'(pg_state), 32'(3));
    step();
    chk("loss_pg_e2", 32'(pg_state), 32'(3));
    chk("loss_stable_e2", 32'(stable), 32'(1));
    chk("loss_clk_e2", 32'(clock_out), 32'(4'b0001));
    step();
    chk("loss_pg_e3", 32'(pg_state), 32'(0));
    chk("loss_stable_e3", 32'(stable), 32'(0));
    chk("loss_clk_e3", 32'(clock_out), 32'(0));
    chk("loss_tick_e3", 32'(tick), 32'(0));

    // Ratios survive power loss: ch0 R=0, ch2 R=2 resume with enables still high.
    powerup("pu2");
    step(); chk("resume_clk_1", 32'(clock_out), 32'(4'b0000));
    step(); chk("resume_clk_2", 32'(clock_out), 32'(4'b0001));
    step(); chk("resume_clk_3", 32'(clock_out), 32'(4'b0000));
    step(); chk("resume_clk_4", 32'(clock_out), 32'(4'b0101));
    chk("resume_tick_4", 32'(tick), 32'(4'b0101));

    // One-cycle synchronous reset mid-run clears ratios: ch2 then divides by 2.
    reset_n = 1'b0;
    step();
    chk("midrst_pg", 32'(pg_state), 32'(0));
    chk("midrst_stable", 32'(stable), 32'(0));
    chk("midrst_clk", 32'(clock_out), 32'(0));
    chk("midrst_tick", 32'(tick), 32'(0));
    reset_n = 1'b1;
    powerup("pu3");
    step(); chk("zero_clk_1", 32'(clock_out), 32'(4'b0000));
    step(); chk("zero_clk_2", 32'(clock_out), 32'(4'b0101));
    chk("zero_tick_2", 32'(tick), 32'(4'b0101));
    step(); chk("zero_clk_3", 32'(clock_out), 32'(4'b0000));
    step(); chk("zero_clk_4", 32'(clock_out), 32'(4'b0101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
